// File: rtl/dec_ark_stage.sv
// rtl/dec_ark_stage.sv - registered AddRoundKey stage with 2-entry skid buffer for the AES-128 inverse cipher
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready is a pure register output)
//   in_state, in_round        state word and its round index
//   round_key                 key for in_round, sampled with in_state
//   out_valid / out_ready     downstream handshake
//   out_state                 head entry: in_state ^ round_key
//   out_round                 head entry round tag
//   out_mix_en                head entry needs inverse MixColumns (gated by out_valid)
//   out_last                  head entry is plaintext (gated by out_valid)
//   err_round                 sticky: a word with round > NR was accepted
//   blk_cnt                   plaintext words handed downstream, wraps at 16 bits
module dec_ark_stage #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_state,
    input  logic [RW-1:0] in_round,
    input  logic [127:0]  round_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_state,
    output logic [RW-1:0] out_round,
    output logic          out_mix_en,
    output logic          out_last,
    output logic          err_round,
    output logic [15:0]   blk_cnt
);

    localparam logic [RW-1:0] NR_TAG = RW'(NR);

    typedef struct packed {
        logic [127:0]  state;
        logic [RW-1:0] round;
        logic          mix_en;
        logic          last;
    } entry_t;

    entry_t        head_q, head_d;
    entry_t        tail_q, tail_d;
    entry_t        new_word;
    logic [1:0]    cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          err_q, err_d;
    logic [15:0]   blk_q, blk_d;
    logic          push, pop;
    logic          bad_round;

    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid_q & out_ready;
    assign bad_round = (in_round > NR_TAG);

    // Tags are resolved at accept time so the downstream mux sees them
    // straight out of a register. An out-of-range round gets neither tag.
    always_comb begin
        new_word        = '0;
        new_word.state  = in_state ^ round_key;
        new_word.round  = in_round;
        new_word.mix_en = (in_round != '0) && (in_round < NR_TAG);
        new_word.last   = (in_round == '0);
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        err_d  = err_q | (push & bad_round);
        blk_d  = (pop && head_q.last) ? blk_q + 16'd1 : blk_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = new_word;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = new_word;
                end else if (push) begin
                    tail_d = new_word;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    // head keeps its contents so out_state/out_round hold
                    cnt_d = 2'd0;
                end
            end
            default: begin
                // full: in_ready_q is low, so only a pop can happen
                if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
        in_ready_d  = (cnt_d != 2'd2);
        out_valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            blk_q       <= 16'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            blk_q       <= blk_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_state  = head_q.state;
    assign out_round  = head_q.round;
    // stale tags of an emptied buffer must not steer downstream logic
    assign out_mix_en = head_q.mix_en & out_valid_q;
    assign out_last   = head_q.last & out_valid_q;
    assign err_round  = err_q;
    assign blk_cnt    = blk_q;

endmodule

// File: doc/dec_ark_stage.md
Name: dec_ark_stage

Overview:
- Registered AddRoundKey stage of the iterative AES-128 inverse cipher.
- Sits directly upstream of the combinational inverse-MixColumns block.
- XORs the incoming state with the round key, tags the result with round information, and buffers it in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Downstream logic uses the mix_en tag to choose between the inverse-MixColumns result and a bypass; the last tag marks finished plaintext.

Parameters:
- NR, 10, number of cipher rounds; legal round tags are 0..NR.
- RW, 4, width of the round tag; must satisfy 2^RW > NR.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers a state word.
- in_ready  out  1  stage can accept a word this cycle.
- in_state  in  128  AES state; byte j at bits [8j+7:8j]; column c = bits [32c+31:32c], matching inverse-MixColumns packing.
- in_round  in  RW  round index of this word (NR down to 0).
- round_key  in  128  round key for in_round; sampled together with in_state.
- out_valid  out  1  buffered result is available.
- out_ready  in  1  downstream accepts the result.
- out_state  out  128  in_state ^ round_key.
- out_round  out  RW  round tag carried through unchanged.
- out_mix_en  out  1  1 when 1 <= out_round <= NR-1 (result must pass through inverse MixColumns).
- out_last  out  1  1 when out_round == 0 (result is plaintext).
- err_round  out  1  sticky flag, set when a word is accepted with in_round > NR.
- blk_cnt  out  16  count of plaintext words (out_last) handed downstream; wraps at 0xFFFF -> 0x0000.

Behaviour:
- Reset (asynchronous, rst=1):
  - Buffer emptied; out_valid=0, in_ready=1.
  - out_state=0, out_round=0, out_mix_en=0, out_last=0, err_round=0, blk_cnt=0.
- Accept: in_valid & in_ready at a rising edge.
  - Word = {in_state^round_key, in_round, mix_en, last}; tags are computed at accept time and stored.
- Latency: 1 cycle. A word accepted into an empty buffer shows out_valid=1 on the next cycle. No combinational path from in_* to out_*.
- Buffer: 2 entries, FIFO order, occupancy 0..2.
  - in_ready = (occupancy < 2), driven from a register only; no combinational dependence on out_ready.
  - Head entry drives out_*.
  - Pop on out_valid & out_ready.
  - out_* stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - At occupancy 1: stays at 1; the new word becomes the head.
  - At occupancy 2: no push is possible (in_ready=0). A pop drops occupancy to 1 and in_ready rises next cycle.
- Empty buffer: out_valid=0, out_* hold their last values; out_mix_en and out_last are gated low.
- blk_cnt increments on each pop with out_last=1; wraps 0xFFFF -> 0x0000.
- err_round:
  - Set on accept with in_round > NR; cleared only by rst.
  - The offending word still passes through with mix_en=0 and last=0.
- Reset mid-operation: buffered words are discarded and no partial pop occurs; in_ready=1 from the first edge after rst deasserts.

Test Plan:
- Round NR, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key 13111d7fe3944a17f307a78b4d2b30c5 -> one cycle later out_state=7ad5fda789ef4e272bca100b3d9ff59f, out_round=10, out_mix_en=0, out_last=0.
- Back-to-back rounds 9..0 with out_ready=1 -> one output per cycle in order; out_mix_en=1 for 9..1; round 0 gives out_last=1 and blk_cnt 0->1.
- Backpressure: out_ready=0, push 3 words -> in_ready=0 after the 2nd accept; 3rd held upstream; out_* stable; release out_ready -> order w1, w2, w3, nothing lost or duplicated.
- Push and pop in the same cycle at occupancy 1 for 20 cycles -> occupancy stays 1, in_ready stays 1, throughput 1 word/cycle.
- in_round=12 accepted -> err_round=1 next cycle and stays set; word emerges with mix_en=0, last=0; rst clears err_round.
- rst asserted with 2 words buffered -> out_valid=0 immediately (asynchronous), blk_cnt=0; preload blk_cnt=0xFFFF via 65535 last pops, one more -> 0x0000.
